// File: rtl/multicycle_processor_if.sv
// Instruction handshake and observation bus of multicycle_processor.
// The bench drives the master side; the processor takes the slave side.
interface multicycle_processor_if #(
  parameter int DATA_W = 32
);
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [DATA_W-1:0] ALU_RESULT;
  logic [DATA_W-1:0] RD;
  logic              retire;
  logic              err;

  modport master (
    output instr_valid, instr,
    input  instr_ready, RD1, RD2, ALU_RESULT, RD, retire, err
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, RD1, RD2, ALU_RESULT, RD, retire, err
  );
endinterface

// File: rtl/multicycle_processor.sv
// Multicycle IDLE/DECODE/EXEC/MEM/WB processor with internal register file and data memory.
// Optional feature: define PROC_MUL_EN to make opcode 000111 a MUL (otherwise illegal).
module multicycle_processor #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int DMEM_AW = 8
)(
  input  logic clk,
  input  logic rst_n,
  multicycle_processor_if.slave bus
);

  localparam int NREG = 1 << REG_AW;
  localparam int NMEM = 1 << DMEM_AW;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_SW  = 6'b000010;
  localparam logic [5:0] OP_SUB = 6'b000011;
  localparam logic [5:0] OP_LW  = 6'b000100;
  localparam logic [5:0] OP_AND = 6'b000101;
  localparam logic [5:0] OP_OR  = 6'b000110;
  localparam logic [5:0] OP_MUL = 6'b000111;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;   // rd lives in imm[15:11]
  } instr_t;

  logic [2:0]        state_q, state_d;
  instr_t            ir_q, ir_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, alu_q, alu_d, rdata_q, rdata_d;
  logic              retire_q, retire_d, err_q, err_d;

  logic [DATA_W-1:0] rf_q  [NREG];
  logic [DATA_W-1:0] mem_q [NMEM];

  logic              rf_we, mem_we;
  logic [REG_AW-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;

  logic [REG_AW-1:0]  rs_a, rt_a, rd_a;
  logic [DATA_W-1:0]  imm_ext, alu_val, rs_val, rt_val;
  logic [DMEM_AW-1:0] maddr;
  logic               is_lw, is_sw, is_alu;

  assign rs_a    = ir_q.rs[REG_AW-1:0];
  assign rt_a    = ir_q.rt[REG_AW-1:0];
  assign rd_a    = ir_q.imm[11 +: REG_AW];
  assign imm_ext = {{(DATA_W-16){ir_q.imm[15]}}, ir_q.imm};
  assign maddr   = alu_q[DMEM_AW-1:0];
  assign rs_val  = (rs_a == '0) ? '0 : rf_q[rs_a];
  assign rt_val  = (rt_a == '0) ? '0 : rf_q[rt_a];

  always_comb begin
    is_lw  = (ir_q.op == OP_LW);
    is_sw  = (ir_q.op == OP_SW);
    is_alu = (ir_q.op == OP_ADD) || (ir_q.op == OP_SUB) ||
             (ir_q.op == OP_AND) || (ir_q.op == OP_OR);
`ifdef PROC_MUL_EN
    is_alu = is_alu || (ir_q.op == OP_MUL);
`endif
  end

  // Memory ops fall into the default arm: address = rs + sign-extended imm.
  always_comb begin
    case (ir_q.op)
      OP_ADD:  alu_val = rd1_q + rd2_q;
      OP_SUB:  alu_val = rd1_q - rd2_q;
      OP_AND:  alu_val = rd1_q & rd2_q;
      OP_OR:   alu_val = rd1_q | rd2_q;
`ifdef PROC_MUL_EN
      OP_MUL:  alu_val = rd1_q * rd2_q;
`endif
      default: alu_val = rd1_q + imm_ext;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    alu_d    = alu_q;
    rdata_d  = rdata_q;
    retire_d = 1'b0;
    err_d    = 1'b0;
    rf_we    = 1'b0;
    rf_wa    = is_lw ? rt_a : rd_a;
    rf_wd    = is_lw ? rdata_q : alu_q;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: if (bus.instr_valid) begin
        ir_d    = bus.instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        rd1_d   = rs_val;
        rd2_d   = rt_val;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          alu_d   = alu_val;
          state_d = S_MEM;
        end else if (is_alu) begin
          alu_d   = alu_val;
          state_d = S_WB;
        end else begin
          retire_d = 1'b1;
          err_d    = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          mem_we   = 1'b1;
          retire_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          rdata_d = mem_q[maddr];
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we    = (rf_wa != '0);
        retire_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      alu_q    <= '0;
      rdata_q  <= '0;
      retire_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= DATA_W'(i);
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      alu_q    <= alu_d;
      rdata_q  <= rdata_d;
      retire_q <= retire_d;
      err_q    <= err_d;
      if (rf_we) rf_q[rf_wa] <= rf_wd;
    end
  end

  // Data memory has no reset; contents are undefined until stored.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[maddr] <= rd2_q;
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.RD1         = rd1_q;
  assign bus.RD2         = rd2_q;
  assign bus.ALU_RESULT  = alu_q;
  assign bus.RD          = rdata_q;
  assign bus.retire      = retire_q;
  assign bus.err         = err_q;

endmodule

// File: doc/multicycle_processor.md
# multicycle_processor

Parametrised multicycle successor to the single-cycle `processor`. It accepts one instruction at a time over a valid/ready handshake and steps it through a decode/execute/memory/write-back state machine. It contains an internal register file and word-addressed data memory. It exposes the same observation outputs (RD1, RD2, RD, ALU_RESULT) plus retire and error strobes for the bench and the future fetch unit.

## Interface
- DATA_W, 32, datapath and register width
- REG_AW, 5, register index width; 2^REG_AW registers; the low REG_AW bits of each 5-bit field are used
- DMEM_AW, 8, data memory word-address width; 2^DMEM_AW words

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruction offered
- instr  in  32  instruction: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm (sign-extended to DATA_W)
- instr_ready  out  1  block can accept (high only in IDLE)
- RD1  out  DATA_W  registered rs operand
- RD2  out  DATA_W  registered rt operand
- ALU_RESULT  out  DATA_W  registered ALU output
- RD  out  DATA_W  registered data-memory read data
- retire  out  1  one-cycle pulse on instruction completion
- err  out  1  one-cycle pulse, coincident with retire, for an illegal opcode

## Operation
- Opcodes:
  - 000001 ADD: rd=rs+rt
  - 000011 SUB: rd=rs-rt
  - 000101 AND: rd=rs&rt
  - 000110 OR: rd=rs|rt
  - 000010 SW: mem[rs+imm]=rt
  - 000100 LW: rt=mem[rs+imm]
  - 000111 MUL: only with PROC_MUL_EN
  - All others are illegal.
- Arithmetic wraps modulo 2^DATA_W; no overflow flag.
- Memory address is ALU_RESULT[DMEM_AW-1:0] as a word index. Out-of-range addresses wrap.
- Register 0 always reads 0. Writes to register 0 are discarded.
- States and transitions:
  - IDLE: go to DECODE when instr_valid && instr_ready; instr is captured into IR.
  - DECODE: latch RD1/RD2 from the register file; go to EXEC.
  - EXEC: latch ALU_RESULT (rs+imm for LW/SW). Go to MEM for LW/SW, WB for ALU ops, IDLE for illegal opcodes.
  - MEM: SW writes memory and goes to IDLE. LW latches RD and goes to WB.
  - WB: write rd (ALU ops) or rt (LW); go to IDLE.
- Output holding:
  - RD1, RD2 and ALU_RESULT hold until overwritten by the next instruction.
  - RD changes only in the MEM state of an LW.
- Reset values:
  - All outputs 0, except instr_ready=1.
  - FSM in IDLE, IR=0.
  - Register i resets to value i; register 0 resets to 0.
  - Data memory is not reset; contents are undefined until written.
- Reset mid-instruction aborts it. No register or memory write occurs unless its WB/MEM edge preceded the rst_n assertion.

## Timing
- instr_ready is combinational from state: 1 in IDLE, 0 otherwise. instr is ignored when instr_ready=0, and instr_valid may be held high across a busy period.
- Counting from the accept edge to retire asserted:
  - ALU op: 3 cycles (DECODE, EXEC, WB)
  - SW: 3 cycles (DECODE, EXEC, MEM)
  - LW: 4 cycles (DECODE, EXEC, MEM, WB)
  - Illegal: 2 cycles (DECODE, EXEC)
- retire and err are asserted in the first IDLE cycle after completion. A new instruction may be accepted in that same cycle, giving back-to-back throughput with no bubble.
- A register written in WB is visible to the next instruction's DECODE; no hazard logic is required.

## Configuration
- PROC_MUL_EN:
  - Defined: opcode 000111 MUL computes rd = low DATA_W bits of rs*rt, with the same 3-cycle ALU latency.
  - Undefined: 000111 is illegal (err pulse, no write) and no multiplier is synthesised.

## Test plan
- ADD after reset: add $1,$2,$3 (0x04430800) -> RD1=2, RD2=3, ALU_RESULT=5; retire 3 cycles after accept; reg1=5.
- Store then load: sw $1,0($2) (0x08410000), then lw $4,0($2) (0x10440000) -> lw ALU_RESULT=2, RD=5, reg4=5; lw retire 4 cycles after accept.
- Wrap: sub $5,$0,$1 with reg1=5 -> ALU_RESULT=0xFFFFFFFB. Then add $6,$5,$6 -> ALU_RESULT=1 (0xFFFFFFFB+6 wraps to 1).
- Handshake: hold instr_valid=1 with two different instructions presented while busy -> only the IDLE-cycle instruction is accepted; instr_ready=0 for exactly 3/4 cycles; back-to-back ADDs retire every 4 cycles.
- Illegal/reg0: opcode 111111 -> err=retire=1 for one cycle, 2 cycles after accept, no state change. add $0,$2,$3 -> a subsequent read of $0 returns 0.
- Reset mid-LW: assert rst_n=0 during MEM -> outputs 0, instr_ready=1, rt unchanged from reset value; MUL test only when PROC_MUL_EN: mul $7,$2,$3 -> 6.
